// File: rtl/sine_pwm_sequencer.sv
// Sine-PWM sequencer: period tick, sine-ROM address stepping, double-buffered duty and registered PWM.
// Optional complementary output with dead time when SINE_SEQ_DEADTIME_EN is defined.
module sine_pwm_sequencer #(
  parameter int PERIOD_W       = 32,
  parameter int ADDR_W         = 8,
  parameter int DEFAULT_PERIOD = 1000
`ifdef SINE_SEQ_DEADTIME_EN
  , parameter int DEADTIME     = 4
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [ADDR_W-1:0]   cfg_step,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [PERIOD_W-1:0] rom_data,
  output logic [PERIOD_W-1:0] width,
  output logic                tick,
  output logic                pwm,
`ifdef SINE_SEQ_DEADTIME_EN
  output logic                pwm_n,
`endif
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  logic [PERIOD_W-1:0] r_cnt, r_period, r_width, r_shadow, r_pend_period;
  logic [ADDR_W-1:0]   r_addr, r_step, r_pend_step;
  logic                r_pend_valid, r_pwm;
  logic [1:0]          r_prime_cnt;
  logic [1:0]          r_tick_dly;

  logic                w_active, w_tick, w_accept, w_apply, w_carry;
  logic [ADDR_W-1:0]   w_addr_next;
  logic [PERIOD_W-1:0] w_cfg_period;

  assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_tick   = w_active && (r_cnt == r_period - PERIOD_W'(1));
  assign {w_carry, w_addr_next} = {1'b0, r_addr} + {1'b0, r_step};
  assign w_accept = cfg_valid && !r_pend_valid;
  assign w_apply  = r_pend_valid && ((r_state == S_IDLE) || w_tick);
  assign w_cfg_period = (cfg_period < PERIOD_W'(4)) ? PERIOD_W'(4) : cfg_period;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_width       <= '0;
      r_shadow      <= '0;
      r_pwm         <= 1'b0;
      r_period      <= PERIOD_W'(DEFAULT_PERIOD);
      r_step        <= ADDR_W'(1);
      r_pend_valid  <= 1'b0;
      r_pend_period <= '0;
      r_pend_step   <= '0;
      r_prime_cnt   <= '0;
      r_tick_dly    <= '0;
    end else begin
      r_tick_dly <= {r_tick_dly[0], w_tick};
      // duty word arrives two cycles after the tick: address register, then ROM latency
      if (r_tick_dly[1])
        r_shadow <= rom_data;

      if (w_apply) begin
        r_period     <= r_pend_period;
        r_step       <= r_pend_step;
        r_pend_valid <= 1'b0;
      end
      if (w_accept) begin
        r_pend_valid  <= 1'b1;
        r_pend_period <= w_cfg_period;
        r_pend_step   <= cfg_step;
      end

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_pwm <= 1'b0;
          if (start && !stop) begin
            r_state     <= S_PRIME;
            r_prime_cnt <= '0;
            r_addr      <= '0;
          end
        end
        S_PRIME: begin
          r_pwm <= 1'b0;
          if (r_prime_cnt == 2'd2) begin
            r_width  <= rom_data;
            r_shadow <= '0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end else begin
            r_prime_cnt <= r_prime_cnt + 2'd1;
          end
        end
        default: begin
          r_pwm <= (r_cnt < r_width);
          if (w_tick) begin
            r_cnt   <= '0;
            r_width <= r_shadow;
            r_addr  <= w_addr_next;
          end else begin
            r_cnt <= r_cnt + PERIOD_W'(1);
          end
          if (r_state == S_RUN) begin
            if (stop)
              r_state <= S_DRAIN;
          end else if (w_tick && w_carry) begin
            // table wrapped: stop cleanly at address 0
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_pwm   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign cfg_ready = ~r_pend_valid;
  assign rom_addr  = r_addr;
  assign width     = r_width;
  assign tick      = w_tick;
  assign busy      = (r_state != S_IDLE);

`ifdef SINE_SEQ_DEADTIME_EN
  localparam int DT_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  logic [DT_W-1:0] r_dt_cnt;
  logic            r_raw_q, r_pwm_p, r_pwm_n;

  // any change of the raw level drops both legs; the new leg rises only after DEADTIME stable cycles
  always_ff @(posedge clk) begin
    if (rst || !w_active) begin
      r_dt_cnt <= '0;
      r_raw_q  <= 1'b0;
      r_pwm_p  <= 1'b0;
      r_pwm_n  <= 1'b0;
    end else if (r_pwm != r_raw_q) begin
      r_raw_q  <= r_pwm;
      r_dt_cnt <= '0;
      r_pwm_p  <= 1'b0;
      r_pwm_n  <= 1'b0;
    end else if (r_dt_cnt != DT_W'(DEADTIME - 1)) begin
      r_dt_cnt <= r_dt_cnt + 1'b1;
    end else begin
      r_pwm_p <= r_raw_q;
      r_pwm_n <= ~r_raw_q;
    end
  end

  assign pwm   = r_pwm_p;
  assign pwm_n = r_pwm_n;
`else
  assign pwm = r_pwm;
`endif

endmodule

// File: tb/tb_sine_pwm_sequencer.sv
// Scoreboard bench for sine_pwm_sequencer: per-period expectations are queued by the stimulus
// and checked by a monitor at every tick (address, width, period length, PWM high count).
`timescale 1ns/1ps
module tb_sine_pwm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_period = '0;
  logic [7:0]  cfg_step = '0;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data = '0;
  logic [31:0] width;
  logic        tick, pwm, busy;
`ifdef SINE_SEQ_DEADTIME_EN
  logic        pwm_n;
`endif

  sine_pwm_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_step(cfg_step),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .width(width), .tick(tick), .pwm(pwm),
`ifdef SINE_SEQ_DEADTIME_EN
    .pwm_n(pwm_n),
`endif
    .busy(busy)
  );

  always #2.5 clk = ~clk;

  logic [31:0] rom_mem [256];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  typedef struct {
    int addr;
    int width;
    int len;
    int pwm;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: samples 1ns after each rising edge
  int   cyc = 0;
  int   last_tick = 0;
  int   acc = 0;
  bit   fin_pending = 0;
  bit   busy_q = 0;
  exp_t cur;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      acc = 0;
      fin_pending = 0;
      busy_q = 0;
    end else begin
      if (busy && !busy_q) begin
        acc = 0;
        last_tick = cyc + 2;
      end
      busy_q = busy;
      acc += int'(pwm);
      if (fin_pending) begin
        chk("pwm_high_cycles", acc, cur.pwm);
        acc = 0;
        fin_pending = 0;
        n_done++;
      end
      if (tick) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_tick: tick at cycle %0d, required none", cyc);
        end else begin
          cur = sb.pop_front();
          chk("tick_rom_addr", rom_addr, cur.addr);
          chk("period_width", width, cur.width);
          chk("period_length", cyc - last_tick, cur.len);
          fin_pending = 1;
        end
        last_tick = cyc;
      end
    end
  end

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_done < target) begin
      n_vec++;
      n_err++;
      $display("FAIL period_timeout: actual %0d periods required %0d", n_done, target);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic do_cfg(input int p, input int s);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_period = p; cfg_step = s[7:0];
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("cfg_ready_after_accept", cfg_ready, 1'b0);
    @(negedge clk);
    chk("cfg_ready_after_idle_apply", cfg_ready, 1'b1);
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic push(input int a, input int w, input int l, input int p);
    exp_t e;
    e.addr = a; e.width = w; e.len = l; e.pwm = p;
    sb.push_back(e);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom_mem[a] = a;

    // reset, then idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("idle_outputs", {pwm, tick, rom_addr, cfg_ready, busy}, {1'b0, 1'b0, 8'd0, 1'b1, 1'b0});
    end
    chk("idle_width", width, 32'd0);

    // basic run with mid-run reconfiguration (12, then 2 -> clamped 4)
    do_cfg(8, 1);
    for (int j = 1; j <= 12; j++) begin
      int w, l;
      w = (j <= 2) ? 0 : j - 2;
      l = (j <= 7) ? 8 : (j <= 10) ? 12 : 4;
      push(j - 1, w, l, (w < l) ? w : l);
    end
    do_start();
    wait_done(6, 200);
    @(negedge clk);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_period = 12; cfg_step = 8'd1;
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk("cfg_ready_held_until_tick", cfg_ready, 1'b0);
      if (tick) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("cfg_ready_after_tick_apply", cfg_ready, 1'b1);
    wait_done(9, 200);
    cfg_valid = 1'b1; cfg_period = 2; cfg_step = 8'd1;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_done(12, 200);

    // reset mid-run with a pending config (period 16 must be discarded)
    cfg_valid = 1'b1; cfg_period = 16; cfg_step = 8'd3;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("cfg_ready_pending", cfg_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {pwm, tick, rom_addr, width, cfg_ready, busy},
        {1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0});
    rst = 1'b0;
    push(0, 0, 1000, 0);
    push(1, 0, 1000, 0);
    do_start();
    wait_done(14, 2200);
    do_reset();

    // saturation: duty 20 with period 8
    do_cfg(8, 1);
    for (int a = 0; a < 256; a++) rom_mem[a] = 20;
    push(0, 20, 8, 8);
    push(1, 0, 8, 0);
    push(2, 20, 8, 8);
    push(3, 20, 8, 8);
    push(4, 20, 8, 8);
    do_start();
    wait_done(19, 200);
    do_reset();

    // saturation: duty 0
    do_cfg(8, 1);
    for (int a = 0; a < 256; a++) rom_mem[a] = 0;
    for (int j = 0; j < 4; j++) push(j, 0, 8, 0);
    do_start();
    wait_done(23, 200);
    do_reset();

    // stop/drain with step 64: drain through 128, 192, exit on wrap
    do_cfg(8, 64);
    for (int a = 0; a < 256; a++) rom_mem[a] = a >> 6;
    push(0, 0, 8, 0);
    push(64, 0, 8, 0);
    push(128, 1, 8, 1);
    push(192, 2, 8, 2);
    do_start();
    wait_done(24, 200);
    chk("rom_addr_at_stop", rom_addr, 8'd64);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(27, 200);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("after_drain_idle", {pwm, tick, rom_addr, busy}, {1'b0, 1'b0, 8'd0, 1'b0});
    end

    // start and stop together in IDLE: stop wins
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("start_stop_stays_idle", {busy, pwm, tick}, {1'b0, 1'b0, 1'b0});
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
